// File: rtl/bram_axis_rd_pkg.sv
// Shared types and elaboration-time helpers for the BRAM-to-AXIS burst reader.
package bram_axis_rd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } rd_state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r == 0) ? 1 : r;
   endfunction

   // Output FIFO must hold every in-flight read plus one beat parked under backpressure.
   function automatic int unsigned fifo_depth(input int unsigned read_latency);
      return read_latency + 2;
   endfunction

   function automatic bit rd_latency_legal(input int unsigned read_latency);
      return (read_latency == 1) || (read_latency == 2);
   endfunction

endpackage

// File: rtl/bram_axis_reader_if.sv
// AXI-Stream style output bus of the BRAM burst reader (data + last, valid/ready).
interface bram_axis_reader_if #(
   parameter int unsigned mem_width = 32
);
   logic [mem_width-1:0] data;
   logic                 last;
   logic                 valid;
   logic                 ready;

   modport master (output data, output last, output valid, input ready);
   modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/bram_axis_rd_fifo.sv
// Small register-based synchronous FIFO with occupancy count; head is read combinationally.
module bram_axis_rd_fifo
   import bram_axis_rd_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = clog2(DEPTH),
   localparam int unsigned CW = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && full && !do_pop));
   end

endmodule

// File: rtl/bram_axis_reader.sv
// Burst read master for a simple dual-port BRAM; streams the words out as AXI-Stream.
// Define BRAM_AXIS_RD_ADDR_WRAP_EN to wrap past the top of memory instead of truncating.
module bram_axis_reader
   import bram_axis_rd_pkg::*;
#(
   parameter int unsigned mem_width        = 32,
   parameter int unsigned mem_depth        = 4096,
   parameter int unsigned read_latency     = 2,
   parameter int unsigned max_len          = 4096,
   parameter int          simulation_delay = 1,
   localparam int unsigned AW = clog2(mem_depth),
   localparam int unsigned LW = clog2(max_len)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [AW-1:0]        cmd_base_addr,
   input  logic [LW-1:0]        cmd_len,
   output logic                 mem_ren,
   output logic [AW-1:0]        mem_addr,
   input  logic [mem_width-1:0] mem_dout,
   bram_axis_reader_if.master   m_axis,
   output logic                 busy
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
   ,
   output logic                 trunc_err
`endif
);
   localparam int unsigned   FIFO_DEPTH = fifo_depth(read_latency);
   localparam int unsigned   CW         = clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] ADDR_MAX   = AW'(mem_depth - 1);
   localparam bit            CFG_OK     = rd_latency_legal(read_latency) && (simulation_delay >= 0);

   rd_state_e               state;
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           issue_idx;
   logic [read_latency-1:0] pipe_vld;
   logic [read_latency-1:0] pipe_lst;
   logic [CW-1:0]           fifo_count;
   logic [CW-1:0]           inflight_count;
   logic                    fifo_empty;
   logic [mem_width:0]      fifo_head;
   logic [mem_width-1:0]    head_data;
   logic                    head_last;
   logic                    head_valid;
   logic                    pop;
   logic                    final_rd;
   logic [AW-1:0]           next_addr;

   always_comb begin
      inflight_count = '0;
      for (int unsigned i = 0; i < read_latency; i++) inflight_count += CW'(pipe_vld[i]);
   end

   // Issue is gated on occupancy already committed, not on this cycle's pop,
   // so a full pipe plus FIFO can never be overrun regardless of ready.
   assign mem_ren = (state == ISSUE) &&
                    (({1'b0, fifo_count} + {1'b0, inflight_count}) < (CW + 1)'(FIFO_DEPTH));

`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
   assign final_rd = (issue_idx == len_q);
`else
   assign final_rd = (issue_idx == len_q) || (mem_addr == ADDR_MAX);
`endif
   assign next_addr = (mem_addr == ADDR_MAX) ? '0 : mem_addr + 1'b1;

   assign {head_last, head_data} = fifo_head;
   assign head_valid   = !fifo_empty;
   assign pop          = head_valid && m_axis.ready;
   assign m_axis.valid = head_valid;
   assign m_axis.data  = head_data;
   assign m_axis.last  = head_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         mem_addr  <= '0;
         len_q     <= '0;
         issue_idx <= '0;
         pipe_vld  <= '0;
         pipe_lst  <= '0;
      end else begin
         pipe_vld[0] <= mem_ren;
         pipe_lst[0] <= mem_ren && final_rd;
         for (int unsigned i = 1; i < read_latency; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_lst[i] <= pipe_lst[i-1];
         end
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  len_q     <= cmd_len;
                  mem_addr  <= cmd_base_addr;
                  issue_idx <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ren) begin
                  mem_addr  <= next_addr;
                  issue_idx <= issue_idx + 1'b1;
                  if (final_rd) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head_last) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   bram_axis_rd_fifo #(
      .WIDTH(mem_width + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pipe_vld[read_latency-1]),
      .push_data ({pipe_lst[read_latency-1], mem_dout}),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
   logic trunc_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trunc_pend <= 1'b0;
         trunc_err  <= 1'b0;
      end else begin
         trunc_err <= pop && head_last && trunc_pend;
         if (state == IDLE) trunc_pend <= 1'b0;
         else if (mem_ren && (mem_addr == ADDR_MAX) && (issue_idx != len_q)) trunc_pend <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n) assert (CFG_OK);
   end

endmodule

// File: tb/tb_bram_axis_reader.sv
// Directed bench for bram_axis_reader: latency-1 and latency-2 instances driven in lockstep,
// each fed by a behavioural BRAM whose word i holds the value i.
module tb_bram_axis_reader;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [11:0] cmd_base;
   logic [11:0] cmd_len;
   logic        ready;

   logic [1:0]        cmdr, ren, v, l, busy_s;
   logic [1:0][11:0]  addr;
   logic [1:0][31:0]  d;
   logic [31:0]       dout_l1, dout_l2;
   logic [11:0]       s1_l2;
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
   logic [1:0]        trunc;
`endif

   int checks   = 0;
   int failures = 0;

   bram_axis_reader_if #(.mem_width(32)) ax1 ();
   bram_axis_reader_if #(.mem_width(32)) ax2 ();

   assign ax1.ready = ready;
   assign ax2.ready = ready;
   assign v[0] = ax1.valid;
   assign l[0] = ax1.last;
   assign d[0] = ax1.data;
   assign v[1] = ax2.valid;
   assign l[1] = ax2.last;
   assign d[1] = ax2.data;

   bram_axis_reader #(
      .mem_width(32), .mem_depth(4096), .read_latency(1), .max_len(4096), .simulation_delay(1)
   ) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmdr[0]),
      .cmd_base_addr(cmd_base), .cmd_len(cmd_len), .mem_ren(ren[0]), .mem_addr(addr[0]),
      .mem_dout(dout_l1), .m_axis(ax1), .busy(busy_s[0])
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
      , .trunc_err(trunc[0])
`endif
   );

   bram_axis_reader #(
      .mem_width(32), .mem_depth(4096), .read_latency(2), .max_len(4096), .simulation_delay(1)
   ) u_dut_l2 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmdr[1]),
      .cmd_base_addr(cmd_base), .cmd_len(cmd_len), .mem_ren(ren[1]), .mem_addr(addr[1]),
      .mem_dout(dout_l2), .m_axis(ax2), .busy(busy_s[1])
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
      , .trunc_err(trunc[1])
`endif
   );

   // BRAM models: word i holds value i, data appears 1 or 2 clk after ren.
   always @(posedge clk) begin
      if (ren[0]) dout_l1 <= 32'(addr[0]);
      if (ren[1]) s1_l2 <= addr[1];
      dout_l2 <= 32'(s1_l2);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_L%0d_outputs", name, i + 1),
               64'({cmdr[i], ren[i], addr[i], v[i], l[i], d[i], busy_s[i]}),
               64'({1'b1, 48'b0}));
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
         check($sformatf("%s_L%0d_trunc_err", name, i + 1), 64'(trunc[i]), 64'(0));
`endif
      end
   endtask

   // Issues one command at the current negedge and follows both instances to completion.
   task automatic run_burst(input string name, input int base, input int len, input logic [3:0] pat,
                            input int exp_beats, input int exp_trunc, input bit chk_cyc);
      int beats [2], last_k [2], busy_n [2], trunc_n [2], outst [2];
      int bad_data [2], bad_last [2], credit_bad [2], stall_bad [2], proto_bad [2];
      bit done [2];
      logic stalled [2], pl [2];
      logic [31:0] pd [2];
      int k, post;
      for (int i = 0; i < 2; i++) begin
         beats[i] = 0; last_k[i] = -1; busy_n[i] = 0; trunc_n[i] = 0; outst[i] = 0;
         bad_data[i] = 0; bad_last[i] = 0; credit_bad[i] = 0; stall_bad[i] = 0; proto_bad[i] = 0;
         done[i] = 1'b0; stalled[i] = 1'b0; pl[i] = 1'b0; pd[i] = '0;
      end
      cmd_base  = 12'(base);
      cmd_len   = 12'(len);
      cmd_valid = 1'b1;
      ready     = pat[0];
      k = 0;
      post = 0;
      while (k < 400 && post < 3) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            if (ren[i]) begin
               if (outst[i] >= i + 3) credit_bad[i]++;
               outst[i]++;
            end
            if (stalled[i] && (v[i] !== 1'b1 || d[i] !== pd[i] || l[i] !== pl[i])) stall_bad[i]++;
            if (cmdr[i] === busy_s[i]) proto_bad[i]++;
            if (busy_s[i]) busy_n[i]++;
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
            if (trunc[i]) trunc_n[i]++;
`endif
            if (v[i] && ready) begin
               outst[i]--;
               if (d[i] !== 32'((base + beats[i]) % 4096)) bad_data[i]++;
               if (l[i] !== (beats[i] == exp_beats - 1)) bad_last[i]++;
               beats[i]++;
               if (l[i] && !done[i]) begin
                  done[i] = 1'b1;
                  last_k[i] = k;
               end
            end
            stalled[i] = v[i] && !ready;
            pd[i] = d[i];
            pl[i] = l[i];
         end
         if (done[0] && done[1]) post++;
         @(negedge clk);
         k++;
         cmd_valid = 1'b0;
         ready = pat[k % 4];
      end
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_L%0d_done", name, i + 1), 64'(done[i]), 64'(1));
         check($sformatf("%s_L%0d_beats", name, i + 1), 64'(beats[i]), 64'(exp_beats));
         check($sformatf("%s_L%0d_data_errs", name, i + 1), 64'(bad_data[i]), 64'(0));
         check($sformatf("%s_L%0d_last_errs", name, i + 1), 64'(bad_last[i]), 64'(0));
         check($sformatf("%s_L%0d_credit_errs", name, i + 1), 64'(credit_bad[i]), 64'(0));
         check($sformatf("%s_L%0d_stall_errs", name, i + 1), 64'(stall_bad[i]), 64'(0));
         check($sformatf("%s_L%0d_ready_vs_busy", name, i + 1), 64'(proto_bad[i]), 64'(0));
         check($sformatf("%s_L%0d_busy_cycles", name, i + 1), 64'(busy_n[i]), 64'(last_k[i]));
         if (chk_cyc)
            check($sformatf("%s_L%0d_last_cycle", name, i + 1), 64'(last_k[i]), 64'(exp_beats + i + 2));
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
`else
         check($sformatf("%s_L%0d_trunc_pulses", name, i + 1), 64'(trunc_n[i]), 64'(exp_trunc));
`endif
      end
   endtask

   typedef struct {
      int         base;
      int         len;
      logic [3:0] pat;
      int         beats;
      int         trunc;
      bit         chk_cyc;
   } vec_t;

   initial begin
      vec_t vecs [7];
      int k, hs;
      int acc [2], acc2_k [2], last_k [2];

      vecs[0] = '{10,   7,  4'b1111, 8,  0, 1'b1};
      vecs[1] = '{0,    0,  4'b1111, 1,  0, 1'b1};
      vecs[2] = '{100,  15, 4'b1001, 16, 0, 1'b0};
`ifdef BRAM_AXIS_RD_ADDR_WRAP_EN
      vecs[3] = '{4094, 3,  4'b1111, 4,  0, 1'b1};
`else
      vecs[3] = '{4094, 3,  4'b1111, 2,  1, 1'b1};
`endif
      vecs[4] = '{4095, 0,  4'b1111, 1,  0, 1'b1};
      vecs[5] = '{7,    5,  4'b0110, 6,  0, 1'b0};
      vecs[6] = '{4000, 4,  4'b1111, 5,  0, 1'b1};

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_base = '0;
      cmd_len = '0;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 7; n++)
         run_burst($sformatf("vec%0d", n), vecs[n].base, vecs[n].len, vecs[n].pat,
                   vecs[n].beats, vecs[n].trunc, vecs[n].chk_cyc);

      // cmd_valid held through a burst: one accept, next one the cycle after busy falls
      cmd_base = 12'd500;
      cmd_len = 12'd3;
      cmd_valid = 1'b1;
      ready = 1'b1;
      k = 0;
      for (int i = 0; i < 2; i++) begin
         acc[i] = 0; acc2_k[i] = -1; last_k[i] = -1;
      end
      while (k < 200 && !(acc[0] >= 2 && acc[1] >= 2)) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            if (cmdr[i] && cmd_valid) begin
               acc[i]++;
               if (acc[i] == 2) acc2_k[i] = k;
            end
            if (v[i] && l[i] && ready && last_k[i] < 0) last_k[i] = k;
         end
         @(negedge clk);
         k++;
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("held_L%0d_first_last_cycle", i + 1), 64'(last_k[i]), 64'(4 + i + 2));
         check($sformatf("held_L%0d_second_accept_cycle", i + 1), 64'(acc2_k[i]), 64'(4 + i + 3));
      end
      k = 0;
      while (k < 100 && (busy_s != 2'b00 || v != 2'b00)) begin
         @(negedge clk);
         k++;
      end
      check("held_drain_idle", 64'({busy_s, v}), 64'(0));
      @(negedge clk);

      // Reset asserted two clocks after the third beat of a long burst
      cmd_base = 12'd300;
      cmd_len = 12'd20;
      cmd_valid = 1'b1;
      ready = 1'b1;
      hs = 0;
      k = 0;
      while (k < 100 && hs < 3) begin
         #1;
         if (v[1] && ready) hs++;
         @(negedge clk);
         k++;
         cmd_valid = 1'b0;
      end
      check("rst_mid_three_beats_seen", 64'(hs), 64'(3));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      run_burst("post_reset", 50, 1, 4'b1111, 2, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bram_axis_reader.md
Name: bram_axis_reader

Overview:
- Read-side master for the simple dual-port block RAM's MEM READ port: drives ren/addr and captures dout after the RAM's fixed read latency of 1 clk (LOW_LATENCY) or 2 clk (HIGH_PERFORMANCE).
- Accepts a burst command (base address, word count) and streams the words out as AXI-Stream with tlast on the final word.
- Sits between line-buffer RAMs and downstream stream consumers (e.g. pooling datapath).
- Credit-based issue plus a small output FIFO absorb the RAM latency under backpressure, sustaining 1 word/clk when m_axis_ready stays high.

Parameters:
- mem_width, 32, RAM data width and AXIS tdata width.
- mem_depth, 4096, RAM depth; address width = clog2(mem_depth).
- read_latency, 2, RAM read latency in clk; legal values 1 or 2 only.
- max_len, 4096, maximum burst length; cmd_len width = clog2(max_len).
- simulation_delay, 1, #delay applied to every nonblocking register assignment.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command valid.
- cmd_ready, output, 1, high only in IDLE.
- cmd_base_addr, input, AW, first word address.
- cmd_len, input, LW, burst length minus 1 (0 means 1 word).
- mem_ren, output, 1, RAM read enable.
- mem_addr, output, AW, RAM read address.
- mem_dout, input, mem_width, RAM read data, valid read_latency clk after mem_ren.
- m_axis_data, output, mem_width, stream data.
- m_axis_last, output, 1, last word of burst.
- m_axis_valid, output, 1, stream valid.
- m_axis_ready, input, 1, stream ready.
- busy, output, 1, high from command accept until the last beat handshakes.

Behaviour:
- Reset (async, rst_n=0), all registered: cmd_ready=1, mem_ren=0, mem_addr=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0, busy=0, FIFO empty, in-flight pipe cleared. FSM returns to IDLE immediately on reset, including mid-burst; partial bursts are discarded.
- FSM states:
  - IDLE: on cmd_valid & cmd_ready, latch base and len, go to ISSUE.
  - ISSUE: issue reads. When the final read issues, go to DRAIN.
  - DRAIN: wait for the last beat handshake, then go to IDLE. busy drops the cycle after that handshake; cmd_ready rises at the same time.
- Read issue:
  - mem_ren=1 in a cycle iff state==ISSUE and (fifo_count + inflight_count) < FIFO_DEPTH.
  - FIFO_DEPTH = read_latency + 2.
  - mem_addr increments after each issued read; mem_addr holds its value when mem_ren=0.
- In-flight tracking:
  - A read_latency-stage valid/last shift register tags each issued read; the last tag is set on the read with index len.
  - The entry is written to the FIFO when it exits the shift register, sampling mem_dout that cycle.
- Output: m_axis_* comes from the FIFO head. Data and last must stay stable while valid & !ready (AXIS rule).
- Simultaneous FIFO push and pop: count is unchanged.
- The FIFO never overflows; overflow is a design error, checked by an assertion.
- Throughput: with ready held high, a burst of N words completes in N + read_latency + 1 clk, from the accept cycle to the last handshake inclusive.
- cmd_valid while busy is ignored: no accept and no side effects.

Optional Feature:
- Macro: BRAM_AXIS_RD_ADDR_WRAP_EN
- Defined: the address wraps from mem_depth-1 to 0 and the burst continues for the full length.
- Undefined:
  - The burst is truncated at address mem_depth-1; that word carries m_axis_last=1.
  - Remaining length is dropped.
  - A 1-clk output pulse trunc_err (extra port, reset 0) fires when the truncated last word handshakes.

Decomposition:
- Package bram_axis_rd_pkg holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN).
  - FIFO_DEPTH derivation.
  - clog2 helper.
  - Legal read_latency check.
- One sub-module: bram_axis_rd_fifo, a register-based synchronous FIFO of depth FIFO_DEPTH, width mem_width+1 (data + last), with exposed count.
- Test instantiates bram_simple_dual_port with read_latency-matching style.

Test Plan:
- Setup: RAM init "default" (mem[i]=i), latency 2, ready=1. cmd base=10, len=7 -> 8 beats with data 10..17, last on 17 only, last handshake 11 clk after accept.
- Latency 1, base=0, len=0 -> single beat with data 0 and last=1; busy high for exactly 3 clk.
- Backpressure: ready toggles 1,0,0,1 repeating, base=100, len=15:
  - data 100..115 in order, no drop or duplicate.
  - data stable while stalled.
  - mem_ren never issued when FIFO count + in-flight = FIFO_DEPTH.
- Wrap, base=4094, len=3, mem_depth=4096:
  - Macro defined: data 4094, 4095, 0, 1.
  - Macro undefined: data 4094, 4095 (last on 4095), trunc_err pulses once.
- Reset mid-burst: rst_n low 2 clk after 3rd beat -> all outputs return to reset values; a new cmd base=50, len=1 then yields 50, 51 cleanly.
- cmd_valid held during a burst -> single accept only; second command accepted in the cycle after busy falls.
